rp_s1_scan: RTL and testbench

- Stage 1 of the rasterizer pipeline, and the producer that feeds stage 2, the barycentric divide stage.
- Accepts one triangle (three screen-space vertices) per start pulse and computes its clipped bounding box and the doubled signed area (the denominator).
- Walks the box one pixel per cycle in raster order. For each pixel it emits the two edge-function numerators, the denominator and a valid flag, in exactly the 36-bit signed format stage 2 consumes.

---
 rtl/rp_pkg.sv | 41 ++++
 rtl/rp_edge_eval.sv | 24 ++
 rtl/rp_s1_scan.sv | 191 +++++++++++++++++++
 tb/tb_rp_s1_scan.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rp_pkg.sv
// Shared types and constants for the rasterizer pipeline.
// Stage 1 (scan) and stage 2 (barycentric divide) both import num_t from here,
// so the numerator/denominator format is defined in one place.
package rp_pkg;

    localparam int COORD_W  = 10;
    localparam int NUM_W    = 36;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam int DELTA_W = COORD_W + 1;
    localparam int PROD_W  = 2 * DELTA_W;
    localparam int DIFF_W  = PROD_W + 1;

    typedef logic        [COORD_W-1:0] coord_t;
    typedef logic signed [DELTA_W-1:0] delta_t;
    typedef logic signed [NUM_W-1:0]   num_t;

    typedef enum logic [1:0] {IDLE, SETUP, SCAN, DONE} scan_state_t;

    localparam coord_t X_LAST = coord_t'(SCREEN_W - 1);
    localparam coord_t Y_LAST = coord_t'(SCREEN_H - 1);

    // Difference of two unsigned coordinates as a signed value one bit wider.
    function automatic delta_t delta_sub(input coord_t a, input coord_t b);
        return delta_t'({1'b0, a}) - delta_t'({1'b0, b});
    endfunction

    function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
        coord_t m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
        coord_t m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rp_edge_eval.sv
// Combinational signed 2-D cross product: cross_o = a_x*b_y - a_y*b_x.
// Ports:
//   a_x_i, a_y_i, b_x_i, b_y_i : signed deltas (COORD_W+1 bits)
//   cross_o                    : full-precision result sign-extended to NUM_W
module rp_edge_eval
    import rp_pkg::*;
(
    input  delta_t a_x_i,
    input  delta_t a_y_i,
    input  delta_t b_x_i,
    input  delta_t b_y_i,
    output num_t   cross_o
);

    logic signed [PROD_W-1:0] prod_p;
    logic signed [PROD_W-1:0] prod_n;
    logic signed [DIFF_W-1:0] diff;

    assign prod_p  = PROD_W'(a_x_i) * PROD_W'(b_y_i);
    assign prod_n  = PROD_W'(a_y_i) * PROD_W'(b_x_i);
    assign diff    = DIFF_W'(prod_p) - DIFF_W'(prod_n);
    assign cross_o = NUM_W'(diff);

endmodule

// File: rtl/rp_s1_scan.sv
// Rasterizer stage 1: latches a triangle, computes its clipped bounding box and
// doubled signed area, then walks the box in raster order emitting the two
// edge-function numerators and the denominator for every pixel.
// Ports:
//   clock, reset              : rising-edge clock, async active-high reset
//   start, x0..y2             : triangle request and vertices (taken in IDLE)
//   pause                     : downstream hold, freezes the scan
//   busy, done                : not-idle flag, one-cycle end-of-triangle pulse
//   data_out                  : qualifies numerator1/2, denominator, pixel_x/y
//
// state | meaning
// IDLE  | waiting for start
// SETUP | register bounding box, deltas and denominator
// SCAN  | emit one pixel per unpaused cycle
// DONE  | pulse done, return to IDLE
module rp_s1_scan
    import rp_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [COORD_W-1:0]        x0,
    input  logic [COORD_W-1:0]        y0,
    input  logic [COORD_W-1:0]        x1,
    input  logic [COORD_W-1:0]        y1,
    input  logic [COORD_W-1:0]        x2,
    input  logic [COORD_W-1:0]        y2,
    input  logic                      pause,
    output logic                      busy,
    output logic                      done,
    output logic                      data_out,
    output logic signed [NUM_W-1:0]   numerator1,
    output logic signed [NUM_W-1:0]   numerator2,
    output logic signed [NUM_W-1:0]   denominator,
    output logic [COORD_W-1:0]        pixel_x,
    output logic [COORD_W-1:0]        pixel_y
);

    scan_state_t state_q, state_d;

    coord_t vx0_q, vy0_q, vx1_q, vy1_q, vx2_q, vy2_q;
    delta_t dx1_q, dy1_q, dx2_q, dy2_q;
    num_t   den_q;
    coord_t xmin_q, xmax_q, ymax_q;
    coord_t px_q, py_q;

    logic   data_out_q, done_q, busy_q;
    logic   data_out_d, done_d, busy_d;
    num_t   n1_q, n2_q, den_out_q;
    coord_t pix_x_q, pix_y_q;

    // Setup-time values derived from the latched vertices.
    delta_t dx1_c, dy1_c, dx2_c, dy2_c;
    coord_t xmin_c, xmax_c, ymin_c, ymax_c, xmax_raw, ymax_raw;
    num_t   den_c;

    assign dx1_c    = delta_sub(vx1_q, vx0_q);
    assign dy1_c    = delta_sub(vy1_q, vy0_q);
    assign dx2_c    = delta_sub(vx2_q, vx0_q);
    assign dy2_c    = delta_sub(vy2_q, vy0_q);
    assign xmin_c   = min3(vx0_q, vx1_q, vx2_q);
    assign ymin_c   = min3(vy0_q, vy1_q, vy2_q);
    assign xmax_raw = max3(vx0_q, vx1_q, vx2_q);
    assign ymax_raw = max3(vy0_q, vy1_q, vy2_q);
    assign xmax_c   = (xmax_raw > X_LAST) ? X_LAST : xmax_raw;
    assign ymax_c   = (ymax_raw > Y_LAST) ? Y_LAST : ymax_raw;

    // Per-pixel offsets from vertex 0.
    delta_t rel_x, rel_y;
    num_t   n1_c, n2_c;

    assign rel_x = delta_sub(px_q, vx0_q);
    assign rel_y = delta_sub(py_q, vy0_q);

    rp_edge_eval u_den (
        .a_x_i   (dx1_c),
        .a_y_i   (dy1_c),
        .b_x_i   (dx2_c),
        .b_y_i   (dy2_c),
        .cross_o (den_c)
    );

    rp_edge_eval u_num1 (
        .a_x_i   (rel_x),
        .a_y_i   (rel_y),
        .b_x_i   (dx2_q),
        .b_y_i   (dy2_q),
        .cross_o (n1_c)
    );

    rp_edge_eval u_num2 (
        .a_x_i   (dx1_q),
        .a_y_i   (dy1_q),
        .b_x_i   (rel_x),
        .b_y_i   (rel_y),
        .cross_o (n2_c)
    );

    logic last_px;
    assign last_px = (px_q == xmax_q) && (py_q == ymax_q);

    // State register and registered control outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            data_out_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = SETUP;
            SETUP: begin
                if ((den_c == '0) || (xmin_c > X_LAST) || (ymin_c > Y_LAST)) state_d = DONE;
                else                                                          state_d = SCAN;
            end
            SCAN:  if (!pause && last_px) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // done is registered on leaving DONE, so it rises on the same edge busy falls.
    always_comb begin
        data_out_d = (state_q == SCAN) && !pause;
        done_d     = (state_q == DONE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vx0_q <= '0; vy0_q <= '0; vx1_q <= '0; vy1_q <= '0; vx2_q <= '0; vy2_q <= '0;
            dx1_q <= '0; dy1_q <= '0; dx2_q <= '0; dy2_q <= '0;
            den_q <= '0;
            xmin_q <= '0; xmax_q <= '0; ymax_q <= '0;
            px_q <= '0; py_q <= '0;
            n1_q <= '0; n2_q <= '0; den_out_q <= '0;
            pix_x_q <= '0; pix_y_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    vx0_q <= x0; vy0_q <= y0;
                    vx1_q <= x1; vy1_q <= y1;
                    vx2_q <= x2; vy2_q <= y2;
                end
                SETUP: begin
                    dx1_q  <= dx1_c; dy1_q <= dy1_c;
                    dx2_q  <= dx2_c; dy2_q <= dy2_c;
                    den_q  <= den_c;
                    xmin_q <= xmin_c;
                    xmax_q <= xmax_c;
                    ymax_q <= ymax_c;
                    px_q   <= xmin_c;
                    py_q   <= ymin_c;
                end
                SCAN: if (!pause) begin
                    n1_q      <= n1_c;
                    n2_q      <= n2_c;
                    den_out_q <= den_q;
                    pix_x_q   <= px_q;
                    pix_y_q   <= py_q;
                    if (px_q != xmax_q) begin
                        px_q <= px_q + coord_t'(1);
                    end else if (py_q != ymax_q) begin
                        px_q <= xmin_q;
                        py_q <= py_q + coord_t'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign data_out    = data_out_q;
    assign numerator1  = n1_q;
    assign numerator2  = n2_q;
    assign denominator = den_out_q;
    assign pixel_x     = pix_x_q;
    assign pixel_y     = pix_y_q;

endmodule

// File: tb/tb_rp_s1_scan.sv
module tb_rp_s1_scan;
    import rp_pkg::*;

    logic   clock = 1'b0;
    logic   reset, start, pause;
    coord_t x0, y0, x1, y1, x2, y2;
    logic   busy, done, data_out;
    num_t   numerator1, numerator2, denominator;
    coord_t pixel_x, pixel_y;

    rp_s1_scan dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .x0          (x0),
        .y0          (y0),
        .x1          (x1),
        .y1          (y1),
        .x2          (x2),
        .y2          (y2),
        .pause       (pause),
        .busy        (busy),
        .done        (done),
        .data_out    (data_out),
        .numerator1  (numerator1),
        .numerator2  (numerator2),
        .denominator (denominator),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int test_id  = 0;

    typedef struct {
        int   x;
        int   y;
        num_t n1;
        num_t n2;
        num_t den;
    } pix_t;

    pix_t exp_q[$];

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Scoreboard monitor: every valid cycle consumes one expected pixel.
    always @(negedge clock) begin : monitor
        pix_t e;
        if (!reset && data_out) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pixel: got (%0d,%0d), required no output", pixel_x, pixel_y);
            end else begin
                e = exp_q.pop_front();
                n_checks++;
                if (pixel_x != e.x || pixel_y != e.y || numerator1 != e.n1 ||
                    numerator2 != e.n2 || denominator != e.den) begin
                    n_fail++;
                    $display("FAIL pixel: got (%0d,%0d) n1=%0d n2=%0d den=%0d, required (%0d,%0d) n1=%0d n2=%0d den=%0d",
                             pixel_x, pixel_y, numerator1, numerator2, denominator,
                             e.x, e.y, e.n1, e.n2, e.den);
                end
            end
            // Hand-computed reference points.
            if (test_id == 1 && pixel_x == 1 && pixel_y == 1) begin
                check("basic_1_1_num1", numerator1, 4);
                check("basic_1_1_num2", numerator2, 4);
                check("basic_den", longint'(denominator), longint'(36'h000000010));
            end
            if (test_id == 1 && pixel_x == 4 && pixel_y == 4) begin
                check("basic_4_4_num1", numerator1, 16);
                check("basic_4_4_num2", numerator2, 16);
            end
            if (test_id == 2 && pixel_x == 1 && pixel_y == 1) begin
                check("rev_1_1_num1", {28'd0, numerator1}, {28'd0, 36'hFFFFFFFFC});
                check("rev_1_1_num2", numerator2, -4);
                check("rev_den", {28'd0, denominator}, {28'd0, 36'hFFFFFFFF0});
            end
            if (test_id == 4) begin
                check("clip_x_range", (pixel_x == 638 || pixel_x == 639) ? 1 : 0, 1);
                check("clip_y_range", (pixel_y <= 2) ? 1 : 0, 1);
            end
        end
    end

    // Expected scan order from the edge-function definitions.
    task automatic push_expected(input int ax0, input int ay0, input int ax1, input int ay1,
                                 input int ax2, input int ay2);
        int     xmin, xmax, ymin, ymax;
        longint den, n1, n2;
        pix_t   e;
        xmin = ax0 < ax1 ? ax0 : ax1; xmin = xmin < ax2 ? xmin : ax2;
        ymin = ay0 < ay1 ? ay0 : ay1; ymin = ymin < ay2 ? ymin : ay2;
        xmax = ax0 > ax1 ? ax0 : ax1; xmax = xmax > ax2 ? xmax : ax2;
        ymax = ay0 > ay1 ? ay0 : ay1; ymax = ymax > ay2 ? ymax : ay2;
        if (xmax > SCREEN_W - 1) xmax = SCREEN_W - 1;
        if (ymax > SCREEN_H - 1) ymax = SCREEN_H - 1;
        den = longint'(ax1 - ax0) * (ay2 - ay0) - longint'(ax2 - ax0) * (ay1 - ay0);
        if (den == 0 || xmin > SCREEN_W - 1 || ymin > SCREEN_H - 1) return;
        for (int py = ymin; py <= ymax; py++) begin
            for (int px = xmin; px <= xmax; px++) begin
                n1 = longint'(px - ax0) * (ay2 - ay0) - longint'(py - ay0) * (ax2 - ax0);
                n2 = longint'(ax1 - ax0) * (py - ay0) - longint'(ay1 - ay0) * (px - ax0);
                e.x = px; e.y = py;
                e.n1 = num_t'(n1); e.n2 = num_t'(n2); e.den = num_t'(den);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic run_tri(input string name, input int tid,
                           input int ax0, input int ay0, input int ax1, input int ay1,
                           input int ax2, input int ay2,
                           input bit pause_en, input bit start_again, input bit reset_at10,
                           input int exp_valid, input int exp_done);
        int k = 0, nvalid = 0, ndone = 0, first_k = -1, last_k = -1, done_k = -1;
        int paused = 0, post = -1;
        bit pause_taken = 0, again_taken = 0;
        test_id = tid;
        push_expected(ax0, ay0, ax1, ay1, ax2, ay2);
        @(negedge clock);
        x0 = coord_t'(ax0); y0 = coord_t'(ay0);
        x1 = coord_t'(ax1); y1 = coord_t'(ay1);
        x2 = coord_t'(ax2); y2 = coord_t'(ay2);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        while (k < 150) begin
            @(posedge clock);
            #1 start = 1'b0;
            @(negedge clock);
            k++;
            if (data_out) begin
                nvalid++;
                if (first_k < 0) first_k = k;
                last_k = k;
            end
            if (done) begin
                ndone++;
                done_k = k;
                check({name, "_busy_low_at_done"}, busy, 0);
                if (post < 0) post = 4;
            end
            if (post == 0) break;
            if (post > 0) post--;
            if (start_again && !again_taken && nvalid == 5) begin
                again_taken = 1;
                x1 = 10'd2; y1 = 10'd7;
                start = 1'b1;
            end
            if (pause_en && !pause_taken && data_out && pixel_x == 2 && pixel_y == 0) begin
                pause_taken = 1;
                pause = 1'b1;
                repeat (3) begin
                    @(posedge clock);
                    @(negedge clock);
                    k++;
                    paused++;
                    check({name, "_pause_hold"}, {data_out, pixel_x, pixel_y}, {1'b0, 10'd2, 10'd0});
                end
                pause = 1'b0;
            end
            if (reset_at10 && nvalid == 10) begin
                #2 reset = 1'b1;
                #1;
                check({name, "_reset_ctrl"}, {busy, done, data_out}, 3'b000);
                check({name, "_reset_data"}, {numerator1, numerator2, denominator, pixel_x, pixel_y}, 0);
                exp_q.delete();
                repeat (2) @(posedge clock);
                #1 reset = 1'b0;
                repeat (5) begin
                    @(negedge clock);
                    if (done) ndone++;
                    if (data_out) nvalid++;
                end
                break;
            end
        end
        check({name, "_valid_count"}, nvalid, exp_valid);
        check({name, "_done_count"}, ndone, exp_done);
        if (exp_valid > 0 && !reset_at10) begin
            check({name, "_first_latency"}, first_k, 2);
            check({name, "_contiguous"}, last_k - first_k + 1, nvalid + paused);
            check({name, "_done_after_last"}, done_k, last_k + 1);
        end
        if (pause_en) check({name, "_pause_seen"}, pause_taken, 1);
        check({name, "_idle_at_end"}, busy, 0);
        check({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; pause = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; x2 = '0; y2 = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_ctrl", {busy, done, data_out}, 3'b000);
        check("reset_data", {numerator1, numerator2, denominator, pixel_x, pixel_y}, 0);
        reset = 1'b0;
        repeat (2) @(posedge clock);

        run_tri("basic",   1, 0, 0, 4, 0, 0, 4, 0, 1, 0, 25, 1);
        run_tri("reverse", 2, 0, 0, 0, 4, 4, 0, 0, 0, 0, 25, 1);
        run_tri("degen",   3, 0, 0, 2, 2, 4, 4, 0, 0, 0, 0, 1);
        run_tri("offscr",  3, 650, 10, 700, 10, 650, 50, 0, 0, 0, 0, 1);
        run_tri("clip",    4, 638, 0, 645, 0, 638, 2, 0, 0, 0, 6, 1);
        run_tri("pause",   1, 0, 0, 4, 0, 0, 4, 1, 0, 0, 25, 1);
        run_tri("rst_mid", 1, 0, 0, 4, 0, 0, 4, 0, 0, 1, 10, 0);
        run_tri("after_rst", 1, 0, 0, 4, 0, 0, 4, 0, 0, 0, 25, 1);

        repeat (3) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
